// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and the queued load-result entry type for the writeback stage.
package wb_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WB_DEPTH_DEF = 2;
  localparam int STARVE_LIMIT_DEF = 4;
  typedef struct packed {
    logic valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular load-result buffer with per-entry squash by destination register.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [REG_ADDR_W-1:0]    push_rd,
  input  logic [XLEN_DEF-1:0]      push_data,
  input  logic                     pop,
  input  logic                     sq_en,
  input  logic [REG_ADDR_W-1:0]    sq_rd,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         ent_valid,
  output logic [REG_ADDR_W-1:0]    ent_rd [DEPTH]
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0] count_q, count_d;
  wb_entry_t [DEPTH-1:0] ent_q, ent_d;
  // squash first so a push landing on the same edge stays live
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++)
      if (sq_en && ent_q[i].rd == sq_rd) ent_d[i].valid = 1'b0;
    if (pop) ent_d[head_q].valid = 1'b0;
    if (push) ent_d[tail_q] = '{valid: 1'b1, rd: push_rd, data: push_data};
    head_d = pop ? head_q + 1'b1 : head_q;
    tail_d = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      ent_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      ent_q <= ent_d;
    end
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ent_q[i].valid;
      ent_rd[i] = ent_q[i].rd;
    end
  end
  assign head = ent_q[head_q];
  assign count = count_q;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: merges ALU and queued load results onto one register-file write port.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int DEPTH = WB_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     pend_mask
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  wb_entry_t head;
  logic [CW-1:0] count;
  logic [DEPTH-1:0] ent_valid;
  logic [4:0] ent_rd [DEPTH];
  logic empty, alu_fire, mem_fire, pop, iss_we;
  logic [4:0] iss_rd;
  logic [XLEN-1:0] iss_data;
  logic [SW-1:0] starve_q, starve_d;
  logic rf_we_q, rf_we_d;
  logic [4:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  assign empty = count == '0;
  assign mem_ready = count != CW'(DEPTH);
  assign alu_ready = !(!empty && starve_q == SW'(STARVE_LIMIT));
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_fire && mem_rd != '0),
    .push_rd   (mem_rd),
    .push_data (mem_data),
    .pop       (pop),
    .sq_en     (alu_fire && alu_rd != '0),
    .sq_rd     (alu_rd),
    .head      (head),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );
  // the counter never passes the limit: at the limit the ALU is blocked and the head drains
  always_comb begin
    alu_fire = alu_valid && alu_ready;
    mem_fire = mem_valid && mem_ready;
    pop = !alu_fire && !empty;
    iss_we = alu_fire ? alu_rd != '0 : pop && head.valid;
    iss_rd = alu_fire ? alu_rd : head.rd;
    iss_data = alu_fire ? alu_data : head.data;
    starve_d = (!empty && alu_fire) ? starve_q + 1'b1 : '0;
    rf_we_d = iss_we;
    rf_rd_d = iss_we ? iss_rd : rf_rd_q;
    rf_wdata_d = iss_we ? iss_data : rf_wdata_q;
  end
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_valid[i]) pend_mask[ent_rd[i]] = 1'b1;
    pend_mask[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end
  assign rf_we = rf_we_q;
  assign rf_rd = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed stimulus with a queue-based reference model checked every cycle.
module tb_wb_stage;
  localparam int LIM = 4;
  localparam int DEP = 2;
  logic clk = 1'b0;
  logic rst;
  logic alu_valid, alu_ready, mem_valid, mem_ready, rf_we;
  logic [4:0] alu_rd, mem_rd, rf_rd;
  logic [31:0] alu_data, mem_data, rf_wdata, pend_mask;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .pend_mask(pend_mask)
  );

  typedef struct {
    logic [4:0] rd;
    logic [31:0] d;
    bit live;
  } ment_t;
  ment_t mq[$];
  ment_t h;
  int m_starve = 0;
  logic m_we = 1'b0;
  logic [4:0] m_rd = '0;
  logic [31:0] m_wd = '0;
  bit started = 1'b0;
  bit af, mf, ne;

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].rd] = 1'b1;
    return m;
  endfunction
  function automatic bit m_ar();
    return !(mq.size() > 0 && m_starve == LIM);
  endfunction
  function automatic bit m_mr();
    return mq.size() < DEP;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      mq.delete();
      m_starve = 0;
      m_we = 1'b0;
      m_rd = '0;
      m_wd = '0;
    end else begin
      af = alu_valid && m_ar();
      mf = mem_valid && m_mr();
      ne = mq.size() > 0;
      m_we = 1'b0;
      if (af) begin
        if (alu_rd != 0) begin
          m_we = 1'b1;
          m_rd = alu_rd;
          m_wd = alu_data;
          foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 1'b0;
        end
      end else if (ne) begin
        h = mq.pop_front();
        if (h.live) begin
          m_we = 1'b1;
          m_rd = h.rd;
          m_wd = h.d;
        end
      end
      m_starve = (ne && af) ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
      if (mf && mem_rd != 0) mq.push_back('{rd: mem_rd, d: mem_data, live: 1'b1});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rf_we", rf_we, m_we);
      chk("rf_rd", rf_rd, m_rd);
      chk("rf_wdata", rf_wdata, m_wd);
      chk("pend_mask", pend_mask, m_mask());
      chk("mem_ready", mem_ready, m_mr());
      chk("alu_ready", alu_ready, m_ar());
    end
  end

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 5'd5, 32'h1, 0, 0, 0);
    tick();
    @(negedge clk);
    chk("rst_we", rf_we, 0);
    chk("rst_ready", mem_ready, 1);
    tick();
    @(negedge clk);
    chk("rst_rd", rf_rd, 0);
    chk("rst_mask", pend_mask, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alu_we", rf_we, 1);
    chk("alu_rd", rf_rd, 5);
    chk("alu_data", rf_wdata, 32'hDEADBEEF);
    drive(0, 0, 0, 1, 5'd7, 32'h12);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ld_pend7", pend_mask, 32'h80);
    chk("ld_nowe", rf_we, 0);
    tick();
    @(negedge clk);
    chk("ld_we", rf_we, 1);
    chk("ld_rd", rf_rd, 7);
    chk("ld_data", rf_wdata, 32'h12);
    chk("ld_mask_clr", pend_mask, 0);
    drive(1, 5'd1, 32'd100, 1, 5'd3, 32'h33);
    tick();
    drive(1, 5'd1, 32'd101, 1, 5'd4, 32'h44);
    tick();
    drive(1, 5'd1, 32'd102, 1, 5'd6, 32'h66);
    @(negedge clk);
    chk("full_ready", mem_ready, 0);
    for (int i = 0; i < 3; i++) begin
      alu_data = 32'd103 + i;
      tick();
    end
    @(negedge clk);
    chk("starve_block", alu_ready, 0);
    tick();
    @(negedge clk);
    chk("starve_rd", rf_rd, 3);
    chk("starve_data", rf_wdata, 32'h33);
    chk("starve_release", alu_ready, 1);
    chk("starve_mask", pend_mask, 32'h10);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    drive(0, 0, 0, 1, 5'd9, 32'h55);
    tick();
    drive(1, 5'd9, 32'hAA, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sq_mask", pend_mask[9], 0);
    chk("sq_data", rf_wdata, 32'hAA);
    tick();
    @(negedge clk);
    chk("sq_drain_we", rf_we, 0);
    chk("sq_hold_data", rf_wdata, 32'hAA);
    drive(1, 5'd0, 32'hBAD0, 1, 5'd0, 32'hBAD1);
    @(negedge clk);
    chk("x0_alu_ready", alu_ready, 1);
    chk("x0_mem_ready", mem_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("x0_we", rf_we, 0);
    chk("x0_mask", pend_mask, 0);
    tick();
    @(negedge clk);
    chk("x0_we2", rf_we, 0);
    drive(1, 5'd1, 32'h1, 1, 5'd10, 32'hA0);
    tick();
    drive(1, 5'd1, 32'h2, 1, 5'd11, 32'hB0);
    tick();
    @(negedge clk);
    chk("pre_rst_mask", pend_mask, 32'h0C00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_rst_mask", pend_mask, 0);
    chk("mid_rst_ready", mem_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("mid_rst_nowe", rf_we, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
